shift_exec_stage: RTL

SHIFT_EXEC_STAGE -- requirements
Module: shift_exec_stage

---
 rtl/shift_exec_stage.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/shift_exec_stage.sv
// Two-stage 32-bit shift execute stage (S1 operand register, S2 result register)
// with valid/ready handshakes on both sides. Define SHIFT_FLAGS_EN to add the flag register.
module shift_exec_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [4:0]  in_b,
    input  logic [1:0]  in_aluc,
    input  logic        in_setflag,
    input  logic [4:0]  in_tag,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_c,
    output logic        out_carry,
    output logic        out_negative,
    output logic        out_zero,
    output logic [4:0]  out_tag
`ifdef SHIFT_FLAGS_EN
    ,
    output logic        flag_c,
    output logic        flag_n,
    output logic        flag_z
`endif
);

    typedef enum logic [1:0] {
        ALU_SRA = 2'b00,
        ALU_SRL = 2'b01
    } aluc_e;

    logic        s1_valid;
    logic [31:0] s1_a;
    logic [4:0]  s1_b;
    logic [1:0]  s1_aluc;
    logic [4:0]  s1_tag;
    logic        s2_valid;

    logic        accept;
    logic        s1_advance;
    logic        out_fire;

    logic [32:0] right_ext;
    logic [32:0] left_ext;
    logic [31:0] sh_c;
    logic        sh_carry;

    assign s1_advance = s1_valid && (!s2_valid || out_ready);
    assign in_ready   = !s1_valid || s1_advance;
    assign accept     = in_valid && in_ready;
    assign out_fire   = s2_valid && out_ready;
    assign out_valid  = s2_valid;

    // One guard bit beyond the operand catches the last bit shifted out; b = 0
    // leaves the guard bit at 0, which gives carry = 0 with c = a for free.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        right_ext = '0;
        left_ext  = '0;
        sh_c      = s1_a;
        sh_carry  = 1'b0;
        case (s1_aluc)
            ALU_SRA: begin
                right_ext = $signed({s1_a, 1'b0}) >>> s1_b;
                sh_c      = right_ext[32:1];
                sh_carry  = right_ext[0];
            end
            ALU_SRL: begin
                right_ext = {s1_a, 1'b0} >> s1_b;
                sh_c      = right_ext[32:1];
                sh_carry  = right_ext[0];
            end
            default: begin
                left_ext = {1'b0, s1_a} << s1_b;
                sh_c     = left_ext[31:0];
                sh_carry = left_ext[32];
            end
        endcase
    end

    // S1 operand register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_aluc  <= '0;
            s1_tag   <= '0;
        end else begin
            if (accept) begin
                s1_a    <= in_a;
                s1_b    <= in_b;
                s1_aluc <= in_aluc;
                s1_tag  <= in_tag;
            end
            if (flush)
                s1_valid <= 1'b0;
            else if (accept)
                s1_valid <= 1'b1;
            else if (s1_advance)
                s1_valid <= 1'b0;
        end
    end

    // S2 result register; only reloads when empty or draining, so it holds under stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid     <= 1'b0;
            out_c        <= '0;
            out_carry    <= 1'b0;
            out_negative <= 1'b0;
            out_zero     <= 1'b0;
            out_tag      <= '0;
        end else begin
            if (s1_advance) begin
                out_c        <= sh_c;
                out_carry    <= sh_carry;
                out_negative <= sh_c[31];
                out_zero     <= (sh_c == 32'd0);
                out_tag      <= s1_tag;
            end
            if (flush)
                s2_valid <= 1'b0;
            else if (s1_advance)
                s2_valid <= 1'b1;
            else if (out_fire)
                s2_valid <= 1'b0;
        end
    end

`ifdef SHIFT_FLAGS_EN
    logic s1_setflag;
    logic s2_setflag;

    // A transfer in the flush cycle is delivered, so flags ignore flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_setflag <= 1'b0;
            s2_setflag <= 1'b0;
            flag_c     <= 1'b0;
            flag_n     <= 1'b0;
            flag_z     <= 1'b0;
        end else begin
            if (accept)
                s1_setflag <= in_setflag;
            if (s1_advance)
                s2_setflag <= s1_setflag;
            if (out_fire && s2_setflag) begin
                flag_c <= out_carry;
                flag_n <= out_negative;
                flag_z <= out_zero;
            end
        end
    end
`else
    logic unused_setflag;
    assign unused_setflag = in_setflag;
`endif

endmodule
